// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Bus widths and reset address mirror the buceros_header definitions.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam logic [INST_ADDR_W-1:0] PC_RST_ADDR = 32'h0000_0000;

    // One decoded-stage entry: the fetch address paired with its instruction word.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } id_entry_t;

    // Width of a counter able to hold the values 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with combinational head read, occupancy count and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [cnt_w(DEPTH)-1:0]    count_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues ibus requests for pc_i, tracks responses in
// order, and buffers {pc, inst} pairs for decode, flushing on jumps.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   jmp_en_i,
    output logic                   hold_o,
    output logic                   ibus_req_o,
    output logic [INST_ADDR_W-1:0] ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [INST_W-1:0]      ibus_rdata_i,
    output logic                   id_valid_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    input  logic                   id_ready_i
);

    localparam int unsigned CW = cnt_w(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    logic                   run_q;
    logic [CW-1:0]          discard_q, discard_d;
    logic [CW-1:0]          pend_count, buf_count;
    logic                   pend_empty, buf_empty;
    logic [INST_ADDR_W-1:0] pend_pc;
    logic [CW:0]            committed;
    logic                   grant, rsp_ok, keep, xfer;
    id_entry_t              buf_wdata, buf_head;

    // Outstanding requests are exactly the entries of the pending-address FIFO.
    assign committed   = {1'b0, pend_count} + {1'b0, buf_count};
    assign ibus_req_o  = run_q & ~jmp_en_i & (committed < DEPTH_LIM);
    assign ibus_addr_o = pc_i;
    assign grant       = ibus_req_o & ibus_gnt_i;
    assign hold_o      = ~grant;

    assign rsp_ok = ibus_rvalid_i & ~pend_empty;
    assign keep   = rsp_ok & (discard_q == '0) & ~jmp_en_i;
    assign xfer   = id_valid_o & id_ready_i;

    assign buf_wdata.pc   = pend_pc;
    assign buf_wdata.inst = ibus_rdata_i;

    assign id_valid_o = ~buf_empty;
    assign id_inst_o  = buf_empty ? '0 : buf_head.inst;
    assign id_pc_o    = buf_empty ? '0 : buf_head.pc;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        discard_d = discard_q;
        if (jmp_en_i) begin
            discard_d = pend_count - CW'(rsp_ok);
        end else if (rsp_ok && discard_q != '0) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            discard_q <= '0;
        end else begin
            run_q     <= 1'b1;
            discard_q <= discard_d;
        end
    end

    if_fifo #(
        .WIDTH (INST_ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pend_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (grant),
        .data_i  (pc_i),
        .pop_i   (rsp_ok),
        .data_o  (pend_pc),
        .count_o (pend_count),
        .empty_o (pend_empty)
    );

    if_fifo #(
        .WIDTH ($bits(id_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (jmp_en_i),
        .push_i  (keep),
        .data_i  (buf_wdata),
        .pop_i   (xfer),
        .data_o  (buf_head),
        .count_o (buf_count),
        .empty_o (buf_empty)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a pc register and ibus responder around the
// DUT, a transaction-level model of the expected decode stream, and directed scenarios.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        jmp_en_i;
    logic        hold_o;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;

    always #5 clk = ~clk;

    if_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .jmp_en_i      (jmp_en_i),
        .hold_o        (hold_o),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .id_ready_i    (id_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        bit          stale;
        int          born;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        rq[$];
    ent_t        exp_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] xfer_log[$];
    int          cyc;
    int          epoch;
    bit          run_m;
    logic [31:0] pc_r;
    int          n_cmp;
    int          n_fail;

    logic        s_req, s_hold, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (rq[i]) if (!rq[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, advance the model.
    task automatic cycle(input bit jmp, input logic [31:0] tgt, input bit gnt,
                         input bit rsp, input bit rdy);
        bit   rv, exp_req, do_xfer;
        req_t r;
        ent_t e;
        pc_i       = pc_r;
        jmp_en_i   = jmp;
        ibus_gnt_i = gnt;
        id_ready_i = rdy;
        rv = rsp && rq.size() > 0 && rq[0].born < cyc;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rv ? mem_word(rq[0].addr) : $urandom;
        #1;
        exp_req = run_m && !jmp && (live_cnt() + exp_q.size() < DEPTH);
        check("req",   {31'b0, ibus_req_o}, {31'b0, exp_req});
        check("hold",  {31'b0, hold_o},     {31'b0, !(exp_req && gnt)});
        check("addr",  ibus_addr_o,         pc_r);
        check("valid", {31'b0, id_valid_o}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("id_pc",   id_pc_o,   exp_q[0].pc);
            check("id_inst", id_inst_o, exp_q[0].inst);
        end
        s_req = ibus_req_o; s_hold = hold_o; s_valid = id_valid_o;
        s_addr = ibus_addr_o; s_pc = id_pc_o; s_inst = id_inst_o;
        if (ibus_req_o && gnt) grant_log.push_back(ibus_addr_o);
        if (id_valid_o && rdy) xfer_log.push_back(id_pc_o);
        do_xfer = exp_q.size() != 0 && rdy;
        @(posedge clk);
        if (do_xfer) void'(exp_q.pop_front());
        if (rv) begin
            r = rq.pop_front();
            if (!r.stale && r.epoch == epoch && !jmp) begin
                e.pc = r.addr;
                e.inst = mem_word(r.addr);
                exp_q.push_back(e);
            end
        end
        if (jmp) exp_q.delete();
        if (exp_req && gnt) begin
            r.addr = pc_r; r.epoch = epoch; r.stale = 1'b0; r.born = cyc;
            rq.push_back(r);
        end
        if (jmp) begin
            epoch++;
            pc_r = tgt;
        end else if (exp_req && gnt) begin
            pc_r = pc_r + 32'd4;
        end
        run_m = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset at a falling edge; late responses survive only when keep_late is set.
    task automatic apply_reset(input bit keep_late);
        rst_n = 1'b0;
        jmp_en_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; id_ready_i = 1'b0;
        #1;
        check("rst_req",   {31'b0, ibus_req_o}, 32'd0);
        check("rst_hold",  {31'b0, hold_o},     32'd1);
        check("rst_valid", {31'b0, id_valid_o}, 32'd0);
        check("rst_inst",  id_inst_o,           32'd0);
        check("rst_pc",    id_pc_o,             32'd0);
        if (keep_late) begin
            foreach (rq[i]) rq[i].stale = 1'b1;
        end else begin
            rq.delete();
        end
        exp_q.delete();
        grant_log.delete();
        xfer_log.delete();
        run_m = 1'b0;
        pc_r  = PC_RST_ADDR;
        pc_i  = pc_r;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; epoch = 0;
        rst_n = 1'b0; pc_r = PC_RST_ADDR; pc_i = pc_r;
        jmp_en_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;
        ibus_rdata_i = '0; id_ready_i = 1'b0;
        @(negedge clk);

        // Streaming fetch with grant always high and one-cycle responses.
        apply_reset(1'b0);
        cycle(0, 0, 1, 1, 1);
        check("s33_run_wait", {31'b0, s_req}, 32'd0);
        repeat (10) cycle(0, 0, 1, 1, 1);
        check("s33_g0", grant_log[0], 32'h0);
        check("s33_g1", grant_log[1], 32'h4);
        check("s33_g2", grant_log[2], 32'h8);
        check("s33_x0", xfer_log[0],  32'h0);
        check("s33_x1", xfer_log[1],  32'h4);
        check("s33_x2", xfer_log[2],  32'h8);

        // Grant withheld for three cycles while a request is pending.
        apply_reset(1'b0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 1);
            check("s34_addr", s_addr, 32'h4);
            check("s34_hold", {31'b0, s_hold}, 32'd1);
            check("s34_req",  {31'b0, s_req},  32'd1);
        end
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 1, 1);
        check("s34_next", s_addr, 32'h8);
        repeat (4) cycle(0, 0, 0, 1, 1);

        // Decode stalled: buffer fills, then one pop frees one request slot.
        apply_reset(1'b0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        check("s35_full_req", {31'b0, s_req}, 32'd0);
        cycle(0, 0, 1, 1, 0);
        check("s35_req",  {31'b0, s_req},  32'd0);
        check("s35_hold", {31'b0, s_hold}, 32'd1);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1);
        check("s35_pop_req", {31'b0, s_req}, 32'd0);
        cycle(0, 0, 1, 1, 0);
        check("s35_one_req", {31'b0, s_req}, 32'd1);
        check("s35_one_addr", s_addr, 32'h8);
        cycle(0, 0, 1, 1, 0);
        check("s35_again_full", {31'b0, s_req}, 32'd0);
        repeat (4) cycle(0, 0, 0, 1, 1);

        // Jump with two requests outstanding: both responses are discarded.
        apply_reset(1'b0);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(1, 32'h100, 1, 0, 1);
        check("s36_jmp_req", {31'b0, s_req}, 32'd0);
        cycle(0, 0, 1, 1, 1);
        check("s36_drop0", {31'b0, s_valid}, 32'd0);
        cycle(0, 0, 1, 1, 1);
        check("s36_drop1", {31'b0, s_valid}, 32'd0);
        check("s36_addr",  s_addr, 32'h100);
        cycle(0, 0, 1, 1, 1);
        check("s36_lat", {31'b0, s_valid}, 32'd0);
        cycle(0, 0, 1, 1, 1);
        check("s36_valid", {31'b0, s_valid}, 32'd1);
        check("s36_pc",    s_pc, 32'h100);
        repeat (3) cycle(0, 0, 0, 1, 1);

        // Jump in the same cycle as a response and a decode transfer.
        apply_reset(1'b0);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 1, 1);
        cycle(1, 32'h200, 1, 1, 1);
        check("s37_xfer_pc", s_pc, 32'h0);
        cycle(0, 0, 1, 1, 1);
        check("s37_no_stale", {31'b0, s_valid}, 32'd0);
        check("s37_addr", s_addr, 32'h200);
        cycle(0, 0, 1, 1, 1);
        check("s37_wait", {31'b0, s_valid}, 32'd0);
        cycle(0, 0, 0, 1, 1);
        check("s37_pc", s_pc, 32'h200);
        check("s37_x1", xfer_log[1], 32'h200);
        repeat (3) cycle(0, 0, 0, 1, 1);

        // Reset with one request in flight; its late response must be ignored.
        apply_reset(1'b0);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        apply_reset(1'b1);
        cycle(0, 0, 0, 1, 1);
        check("s38_run_wait", {31'b0, s_req}, 32'd0);
        cycle(0, 0, 1, 1, 1);
        check("s38_addr",  s_addr, PC_RST_ADDR);
        check("s38_valid", {31'b0, s_valid}, 32'd0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        check("s38_pc",   s_pc,   32'h0);
        check("s38_inst", s_inst, 32'hFFFF_FFFF);

        // Mixed traffic with occasional jumps, checked by the model every cycle.
        apply_reset(1'b0);
        for (int i = 0; i < 120; i++) begin
            cycle($urandom_range(0, 9) == 0, 32'h1000 + ($urandom_range(0, 63) << 2),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
